// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel strobe, DrawX/DrawY, sync, blanking and frame events.
// Latency: decoded outputs are combinational from hc/vc; FrameStart is registered (1 Clk after the wrap edge).
// Backpressure: none; free-running, and only Reset stalls and restarts the raster.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       PixelEn,
  output logic       PixelClk,
  output logic       hs,
  output logic       vs,
  output logic       Blank,
  output logic       sync,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       FrameStart,
  output logic       VBlank,
  output logic [7:0] FrameCount
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] HC_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] VC_LAST = 10'(V_TOTAL - 1);

  // 11-bit bounds so a window edge landing exactly on 1024 still compares correctly.
  localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [9:0]       hc;
  logic [9:0]       vc;
  logic             div_last;
  logic             line_end;
  logic             frame_end;
  logic [10:0]      hc_x;
  logic [10:0]      vc_x;

  assign div_last  = (div == DIV_LAST);
  assign line_end  = (hc == HC_LAST);
  assign frame_end = line_end && (vc == VC_LAST);
  assign hc_x      = {1'b0, hc};
  assign vc_x      = {1'b0, vc};

  // Clk-rate divider; the last count of each period is the pixel strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div <= '0;
    end else if (div_last) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Raster counters advance one pixel per strobe, wrapping line then frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hc <= '0;
      vc <= '0;
    end else if (div_last) begin
      if (line_end) begin
        hc <= '0;
        vc <= (vc == VC_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // Frame events: one-Clk pulse and completed-frame count on the wrap to (0,0).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      FrameStart <= 1'b0;
      FrameCount <= '0;
    end else begin
      FrameStart <= div_last && frame_end;
      if (div_last && frame_end) begin
        FrameCount <= FrameCount + 8'd1;
      end
    end
  end

  // Decoded raster outputs; sync/blank forced inactive while Reset is held.
  always_comb begin
    PixelEn  = div_last && !Reset;
    PixelClk = (div >= DIV_HALF);
    Blank    = !Reset && (hc_x < H_VIS_END) && (vc_x < V_VIS_END);
    hs       = Reset || !((hc_x >= HS_START) && (hc_x < HS_END));
    vs       = Reset || !((vc_x >= VS_START) && (vc_x < VS_END));
    VBlank   = (vc_x >= V_VIS_END);
    sync     = 1'b0;
    DrawX    = hc;
    DrawY    = vc;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (small raster with divide-by-2, tiny raster with divide-by-1).
// Latency: outputs compared every Clk on the falling edge against an arithmetic raster model.
// Backpressure: none; resets are directed plus randomly injected.
module tb_vga_timing_gen;

  typedef struct packed {
    int hv; int hf; int hsy; int hb;
    int vv; int vf; int vsy; int vb;
    int d;
  } tcfg_t;

  typedef struct packed {
    logic [7:0] flags;  // {PixelEn, PixelClk, hs, vs, Blank, sync, VBlank, FrameStart}
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] fc;
  } exp_t;

  localparam tcfg_t CA = '{hv:16, hf:4, hsy:6, hb:4, vv:8, vf:2, vsy:2, vb:3, d:2};
  localparam tcfg_t CB = '{hv:4,  hf:1, hsy:1, hb:1, vv:2, vf:1, vsy:1, vb:1, d:1};
  localparam int    N_CYC = 11000;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic       pe_a, pclk_a, hs_a, vs_a, blank_a, sync_a, fs_a, vblank_a;
  logic       pe_b, pclk_b, hs_b, vs_b, blank_b, sync_b, fs_b, vblank_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [7:0] fc_a, fc_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .CLK_DIV(2)
  ) dut_a (
    .Clk(clk), .Reset(rst_a), .PixelEn(pe_a), .PixelClk(pclk_a), .hs(hs_a), .vs(vs_a),
    .Blank(blank_a), .sync(sync_a), .DrawX(x_a), .DrawY(y_a), .FrameStart(fs_a),
    .VBlank(vblank_a), .FrameCount(fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CLK_DIV(1)
  ) dut_b (
    .Clk(clk), .Reset(rst_b), .PixelEn(pe_b), .PixelClk(pclk_b), .hs(hs_b), .vs(vs_b),
    .Blank(blank_b), .sync(sync_b), .DrawX(x_b), .DrawY(y_b), .FrameStart(fs_b),
    .VBlank(vblank_b), .FrameCount(fc_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Everything follows from t = Clk edges since reset released: t/d pixels
  // have been emitted, so position and frame number are plain div/mod.
  function automatic exp_t model(input tcfg_t c, input int t, input bit rst);
    exp_t e;
    int ht, vt, fr, n, hc, vc, dv;
    bit pe, pclk, blank, hs, vs, vbl, fs;
    ht    = c.hv + c.hf + c.hsy + c.hb;
    vt    = c.vv + c.vf + c.vsy + c.vb;
    fr    = ht * vt;
    n     = t / c.d;
    dv    = t % c.d;
    hc    = n % ht;
    vc    = (n / ht) % vt;
    pe    = !rst && (dv == c.d - 1);
    pclk  = (dv >= c.d / 2);
    blank = !rst && (hc < c.hv) && (vc < c.vv);
    hs    = rst || !((hc >= c.hv + c.hf) && (hc < c.hv + c.hf + c.hsy));
    vs    = rst || !((vc >= c.vv + c.vf) && (vc < c.vv + c.vf + c.vsy));
    vbl   = (vc >= c.vv);
    fs    = (t > 0) && (dv == 0) && (n > 0) && (n % fr == 0);
    e.flags = {pe, pclk, hs, vs, blank, 1'b0, vbl, fs};
    e.x     = 10'(hc);
    e.y     = 10'(vc);
    e.fc    = 8'((n / fr) % 256);
    return e;
  endfunction

  task automatic check_dut(input string nm, input tcfg_t c, input int t, input bit rst,
                           input logic [7:0] flags, input logic [9:0] x, input logic [9:0] y,
                           input logic [7:0] fc);
    exp_t e;
    e = model(c, t, rst);
    chk({nm, ".flags"},      {24'd0, flags}, {24'd0, e.flags});
    chk({nm, ".DrawX"},      {22'd0, x},     {22'd0, e.x});
    chk({nm, ".DrawY"},      {22'd0, y},     {22'd0, e.y});
    chk({nm, ".FrameCount"}, {24'd0, fc},    {24'd0, e.fc});
  endtask

  initial begin
    int   t_a, t_b, cnt_a, cnt_b;
    bit   mid_done, wrap_seen, mid_hit;
    logic [7:0] prev_fc_b;
    exp_t ea;
    t_a = 0; t_b = 0; cnt_a = 0; cnt_b = 0;
    mid_done = 0; wrap_seen = 0; mid_hit = 0;
    prev_fc_b = 8'd0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      t_a = rst_a ? 0 : t_a + 1;
      t_b = rst_b ? 0 : t_b + 1;
      @(negedge clk);
      check_dut("a", CA, t_a, rst_a,
                {pe_a, pclk_a, hs_a, vs_a, blank_a, sync_a, vblank_a, fs_a}, x_a, y_a, fc_a);
      check_dut("b", CB, t_b, rst_b,
                {pe_b, pclk_b, hs_b, vs_b, blank_b, sync_b, vblank_b, fs_b}, x_b, y_b, fc_b);

      if (!rst_b && prev_fc_b == 8'd255 && fc_b == 8'd0) wrap_seen = 1;
      prev_fc_b = fc_b;
      if (mid_done && rst_a == 1'b0 && mid_hit) begin
        chk("a.mid_reset_hs", {31'd0, hs_a}, 32'd1);
        mid_hit = 0;
      end

      // Instance a: 5-cycle reset, one directed reset inside the hsync window, then random resets.
      ea = model(CA, t_a, 1'b0);
      if (cyc < 4) begin
        rst_a = 1'b1;
      end else if (cyc >= 1200 && !mid_done && !rst_a && ea.flags[5] == 1'b0 && ea.y == 10'd5) begin
        rst_a    = 1'b1;
        mid_done = 1;
        mid_hit  = 1;
      end else if (cnt_a > 0) begin
        rst_a = 1'b1;
        cnt_a--;
      end else if (cyc >= 2500 && $urandom_range(0, 299) == 0) begin
        rst_a = 1'b1;
        cnt_a = $urandom_range(0, 2);
      end else begin
        rst_a = 1'b0;
      end

      // Instance b: long reset-free run through 256+ frame wraps, then random resets.
      if (cyc < 2) begin
        rst_b = 1'b1;
      end else if (cnt_b > 0) begin
        rst_b = 1'b1;
        cnt_b--;
      end else if (cyc >= 9500 && $urandom_range(0, 99) == 0) begin
        rst_b = 1'b1;
        cnt_b = $urandom_range(0, 2);
      end else begin
        rst_b = 1'b0;
      end
    end
    chk("b.fc_wrap_255_to_0", {31'd0, wrap_seen}, 32'd1);
    chk("a.mid_reset_taken",  {31'd0, mid_done},  32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
